// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci SRAM controller: FSM state encoding
// and the default address/data widths used by the controller and its SRAM.
// No logic; imported by fib_sram_ctrl.
package fib_pkg;

    localparam int FIB_ADDR_W = 8;
    localparam int FIB_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GEN      = 3'd1,
        DONE     = 3'd2,
        RD_ISSUE = 3'd3,
        RD_CAPT  = 3'd4,
        RD_OUT   = 3'd5
    } fib_state_t;

endpackage

// File: rtl/fib_sram_ctrl.sv
// Purpose: writes the Fibonacci sequence into an external SRAM, then serves single-word readbacks.
// Latency: first write the cycle after start, one term per cycle; readback data 3 cycles after rd_req.
// Backpressure: start/rd_req are ignored while rd_ready is low (GEN and RD_* states); nothing queues.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start, n_terms               launch a run of min(n_terms, 2^ADDR_WIDTH) terms
//   rd_req, rd_addr              readback request (accepted only while rd_ready=1)
//   rd_ready, rd_valid, rd_data  readback handshake and registered data
//   busy, done, overflow         run status; done/overflow sticky until the next start
//   term_count                   terms written by the current/last run
//   mem_we, mem_oe, mem_addr,
//   mem_din, mem_dout            SRAM wrapper interface (one-cycle read latency)
module fib_sram_ctrl
    import fib_pkg::*;
#(
    parameter int ADDR_WIDTH = FIB_ADDR_W,
    parameter int DATA_WIDTH = FIB_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_terms,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   term_count,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [ADDR_WIDTH:0] MAX_TERMS = {1'b1, {ADDR_WIDTH{1'b0}}};

    fib_state_t            state, nxt_state;
    logic                  ret_done, nxt_ret_done;   // readback returns to DONE (1) or IDLE (0)
    logic [ADDR_WIDTH:0]   n_lim, nxt_n_lim;
    logic [ADDR_WIDTH:0]   nxt_tc;
    logic [ADDR_WIDTH-1:0] rd_addr_q, nxt_rd_addr;
    logic                  nxt_done, nxt_ovf;

    // a is the term written this GEN cycle, b the one after it. The *_c bits
    // record that the term did not fit in DATA_WIDTH; such a term is never written.
    logic [DATA_WIDTH-1:0] a, b, nxt_a, nxt_b;
    logic                  a_c, b_c, nxt_a_c, nxt_b_c;
    logic [DATA_WIDTH:0]   sum;
    logic                  nxt_we;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        nxt_state    = state;
        nxt_ret_done = ret_done;
        nxt_n_lim    = n_lim;
        nxt_tc       = term_count;
        nxt_rd_addr  = rd_addr_q;
        nxt_a        = a;
        nxt_a_c      = a_c;
        nxt_b        = b;
        nxt_b_c      = b_c;
        nxt_done     = done;
        nxt_ovf      = overflow;

        case (state)
            IDLE, DONE: begin
                // start has priority; a simultaneous rd_req is dropped
                if (start) begin
                    nxt_state = GEN;
                    nxt_n_lim = (n_terms > MAX_TERMS) ? MAX_TERMS : n_terms;
                    nxt_tc    = '0;
                    nxt_a     = '0;
                    nxt_a_c   = 1'b0;
                    nxt_b     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                    nxt_b_c   = 1'b0;
                    nxt_done  = 1'b0;
                    nxt_ovf   = 1'b0;
                end else if (rd_req && rd_ready) begin
                    nxt_state    = RD_ISSUE;
                    nxt_rd_addr  = rd_addr;
                    nxt_ret_done = (state == DONE);
                end
            end
            GEN: begin
                if (term_count == n_lim) begin
                    nxt_state = DONE;
                    nxt_done  = 1'b1;
                end else if (a_c) begin
                    nxt_state = DONE;
                    nxt_done  = 1'b1;
                    nxt_ovf   = 1'b1;
                end else begin
                    nxt_tc  = term_count + 1'b1;
                    nxt_a   = b;
                    nxt_a_c = b_c;
                    nxt_b   = sum[DATA_WIDTH-1:0];
                    nxt_b_c = sum[DATA_WIDTH];
                end
            end
            RD_ISSUE: nxt_state = RD_CAPT;
            RD_CAPT:  nxt_state = RD_OUT;
            RD_OUT:   nxt_state = ret_done ? DONE : IDLE;
            default:  nxt_state = IDLE;
        endcase

        // SRAM strobes are registered, so decide next cycle's write from next-state values
        nxt_we = (nxt_state == GEN) && (nxt_tc != nxt_n_lim) && !nxt_a_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ret_done   <= 1'b0;
            n_lim      <= '0;
            term_count <= '0;
            rd_addr_q  <= '0;
            a          <= '0;
            a_c        <= 1'b0;
            b          <= '0;
            b_c        <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            rd_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            state      <= nxt_state;
            ret_done   <= nxt_ret_done;
            n_lim      <= nxt_n_lim;
            term_count <= nxt_tc;
            rd_addr_q  <= nxt_rd_addr;
            a          <= nxt_a;
            a_c        <= nxt_a_c;
            b          <= nxt_b;
            b_c        <= nxt_b_c;
            done       <= nxt_done;
            overflow   <= nxt_ovf;
            busy       <= (nxt_state == GEN);
            rd_ready   <= (nxt_state == IDLE) || (nxt_state == DONE);
            rd_valid   <= (nxt_state == RD_OUT);
            mem_we     <= nxt_we;
            mem_oe     <= (nxt_state == RD_ISSUE);
            if (nxt_state == RD_ISSUE) begin
                mem_addr <= nxt_rd_addr;
            end else if (nxt_we) begin
                mem_addr <= nxt_tc[ADDR_WIDTH-1:0];
            end else begin
                mem_addr <= '0;
            end
            mem_din    <= nxt_we ? nxt_a : '0;
            // SRAM presented the word at the end of RD_ISSUE; hold it until the next capture
            if (state == RD_CAPT) begin
                rd_data <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_fib_sram_ctrl.sv
// Bench for fib_sram_ctrl with a one-cycle-latency SRAM model. A Fibonacci
// model builds the expected write list and memory image; a negedge monitor
// checks every SRAM access and readback against it.
module tb_fib_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] n_terms;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ready, rd_valid, busy, done, overflow;
    logic [7:0] rd_data;
    logic [8:0] term_count;
    logic       mem_we, mem_oe;
    logic [7:0] mem_addr, mem_din, mem_dout;

    fib_sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
        .overflow(overflow), .term_count(term_count), .mem_we(mem_we),
        .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // SRAM model, one-cycle read latency
    logic [7:0] sram [256];
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 8'h00;
        mem_dout = 8'h00;
    end
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_din;
        if (mem_oe) mem_dout <= sram[mem_addr];
    end

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_wq[$];
    int  exp_oq[$];
    int  exp_dq[$];
    int  model_mem [256];
    int  exp_cnt, exp_ovf;
    int  n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fibonacci model: terms 0,1,1,2,... until the clipped count or an 8-bit overflow
    task automatic plan_run(input int n);
        int lim, x, y, t, cnt;
        lim = (n > 256) ? 256 : n;
        x = 0; y = 1; cnt = 0;
        while (cnt < lim && x <= 255) begin
            exp_wq.push_back('{addr: cnt, data: x});
            model_mem[cnt] = x;
            t = x + y; x = y; y = t;
            cnt++;
        end
        exp_cnt = cnt;
        exp_ovf = (cnt < lim) ? 1 : 0;
    endtask

    // Monitor: every SRAM access and readback must be one the model expects
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                chk("we_oe_excl", {31'd0, mem_oe}, 32'd0);
                if (exp_wq.size() == 0) chk("unexpected_we", {31'd0, mem_we}, 32'd0);
                else begin
                    wr_t e;
                    e = exp_wq.pop_front();
                    chk("wr_addr", {24'd0, mem_addr}, e.addr);
                    chk("wr_data", {24'd0, mem_din}, e.data);
                end
            end
            if (mem_oe) begin
                if (exp_oq.size() == 0) chk("unexpected_oe", {31'd0, mem_oe}, 32'd0);
                else chk("oe_addr", {24'd0, mem_addr}, exp_oq.pop_front());
            end
            if (rd_valid) begin
                if (exp_dq.size() == 0) chk("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
                else chk("rd_data", {24'd0, rd_data}, exp_dq.pop_front());
            end
        end
    end

    task automatic do_run(input int n, input bit with_rd, input bit noise);
        int cyc;
        plan_run(n);
        start = 1'b1; n_terms = n[8:0]; rd_req = with_rd; rd_addr = 8'd3;
        tick();
        start = 1'b0; rd_req = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("rd_ready_gen", {31'd0, rd_ready}, 32'd0);
        cyc = 1;
        while (!done && cyc < 600) begin
            if (noise) begin rd_req = 1'b1; start = 1'b1; rd_addr = 8'd1; end
            tick();
            rd_req = 1'b0; start = 1'b0;
            cyc++;
        end
        chk("done_latency", cyc, exp_cnt + 2);
        chk("term_count", {23'd0, term_count}, exp_cnt);
        chk("overflow", {31'd0, overflow}, exp_ovf);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("writes_all_seen", exp_wq.size(), 32'd0);
    endtask

    task automatic do_read(input int addr, input int lit);
        exp_oq.push_back(addr);
        exp_dq.push_back(model_mem[addr]);
        rd_req = 1'b1; rd_addr = addr[7:0];
        tick();
        rd_req = 1'b0;
        chk("oe_t1", {31'd0, mem_oe}, 32'd1);
        chk("oe_addr_t1", {24'd0, mem_addr}, addr);
        chk("rdy_t1", {31'd0, rd_ready}, 32'd0);
        tick();
        chk("valid_t2", {31'd0, rd_valid}, 32'd0);
        tick();
        chk("valid_t3", {31'd0, rd_valid}, 32'd1);
        chk("rd_data_literal", {24'd0, rd_data}, lit);
        tick();
        chk("valid_t4", {31'd0, rd_valid}, 32'd0);
        chk("rdy_t4", {31'd0, rd_ready}, 32'd1);
        chk("rd_data_hold", {24'd0, rd_data}, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; n_terms = '0; rd_req = 1'b0; rd_addr = '0;
        @(negedge clk);
        chk("rst_flags", {25'd0, rd_ready, rd_valid, busy, done, overflow, mem_we, mem_oe}, 32'd0);
        chk("rst_term_count", {23'd0, term_count}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        chk("idle_rd_ready", {31'd0, rd_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 10 terms, then readbacks
        do_run(10, 1'b0, 1'b0);
        chk("lit_tc10", {23'd0, term_count}, 32'd10);
        chk("lit_ovf10", {31'd0, overflow}, 32'd0);
        chk("lit_done10", {31'd0, done}, 32'd1);
        do_read(9, 34);
        do_read(0, 0);
        do_read(5, 5);

        // overflow run with rd_req/start noise during GEN
        do_run(20, 1'b0, 1'b1);
        chk("lit_tc20", {23'd0, term_count}, 32'd14);
        chk("lit_ovf20", {31'd0, overflow}, 32'd1);
        do_read(13, 233);

        // exactly the last representable term: no overflow
        do_run(14, 1'b0, 1'b0);
        chk("lit_ovf14", {31'd0, overflow}, 32'd0);

        // zero terms
        do_run(0, 1'b0, 1'b0);
        chk("lit_tc0", {23'd0, term_count}, 32'd0);

        // start and rd_req together from DONE: start wins
        do_run(5, 1'b1, 1'b0);
        chk("lit_tc5", {23'd0, term_count}, 32'd5);

        // above 2^ADDR_WIDTH clips; overflow still ends it
        do_run(300, 1'b0, 1'b0);
        chk("lit_tc300", {23'd0, term_count}, 32'd14);

        // reset mid-GEN
        plan_run(10);
        start = 1'b1; n_terms = 9'd10;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        exp_wq.delete(); exp_oq.delete(); exp_dq.delete();
        #1;
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_tc", {23'd0, term_count}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_we) cnt++;
        end
        chk("no_we_after_rst", cnt, 32'd0);
        chk("idle_after_rst", {30'd0, rd_ready, done}, 32'd2);

        // reset mid-readback
        rd_req = 1'b1; rd_addr = 8'd7;
        tick();
        rd_req = 1'b0;
        chk("rd_issue_oe", {31'd0, mem_oe}, 32'd1);
        #2 rst = 1'b1;
        exp_oq.delete(); exp_dq.delete();
        #1;
        chk("abort_oe", {31'd0, mem_oe}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rd_valid) cnt++;
        end
        chk("no_rd_valid_after_rst", cnt, 32'd0);

        // SRAM contents survive reset
        do_read(4, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
